// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle raster scan controller.
package raster_pkg;

  localparam int COORD_W = 16;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Slot of each vertex coordinate in the packed {x0,y0,x1,y1,x2,y2} bus.
  localparam int VX0 = 5;
  localparam int VY0 = 4;
  localparam int VX1 = 3;
  localparam int VY1 = 2;
  localparam int VX2 = 1;
  localparam int VY2 = 0;

endpackage

// File: rtl/raster_bbox.sv
// Combinational triangle bounding box, clamped to [0,width-1] x [0,height-1].
// empty flags a non-positive screen or a box lying wholly off-screen.
module raster_bbox #(
  parameter int COORD_W = 16
) (
  input  logic [6*COORD_W-1:0]       triangle,
  input  logic signed [COORD_W-1:0]  width,
  input  logic signed [COORD_W-1:0]  height,
  output logic signed [COORD_W-1:0]  min_x,
  output logic signed [COORD_W-1:0]  min_y,
  output logic signed [COORD_W-1:0]  max_x,
  output logic signed [COORD_W-1:0]  max_y,
  output logic                       empty
);
  import raster_pkg::*;

  localparam logic signed [COORD_W:0] ONE_W = {{COORD_W{1'b0}}, 1'b1};

  function automatic logic signed [COORD_W-1:0] smin3(input logic signed [COORD_W-1:0] a,
                                                      input logic signed [COORD_W-1:0] b,
                                                      input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] smax3(input logic signed [COORD_W-1:0] a,
                                                      input logic signed [COORD_W-1:0] b,
                                                      input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic signed [COORD_W-1:0] vtx [6];

  for (genvar i = 0; i < 6; i++) begin : g_vtx
    assign vtx[i] = triangle[i*COORD_W +: COORD_W];
  end

  logic signed [COORD_W-1:0] raw_min_x, raw_min_y, raw_max_x, raw_max_y;
  logic signed [COORD_W:0]   w_m1, h_m1, ext_max_x, ext_max_y;
  logic                      w_nonpos, h_nonpos;

  always_comb begin
    raw_min_x = smin3(vtx[VX0], vtx[VX1], vtx[VX2]);
    raw_min_y = smin3(vtx[VY0], vtx[VY1], vtx[VY2]);
    raw_max_x = smax3(vtx[VX0], vtx[VX1], vtx[VX2]);
    raw_max_y = smax3(vtx[VY0], vtx[VY1], vtx[VY2]);

    // One extra bit so width-1 cannot wrap when width is the most negative value.
    w_m1      = {width[COORD_W-1], width} - ONE_W;
    h_m1      = {height[COORD_W-1], height} - ONE_W;
    ext_max_x = {raw_max_x[COORD_W-1], raw_max_x};
    ext_max_y = {raw_max_y[COORD_W-1], raw_max_y};

    min_x = raw_min_x[COORD_W-1] ? '0 : raw_min_x;
    min_y = raw_min_y[COORD_W-1] ? '0 : raw_min_y;
    max_x = (ext_max_x > w_m1) ? w_m1[COORD_W-1:0] : raw_max_x;
    max_y = (ext_max_y > h_m1) ? h_m1[COORD_W-1:0] : raw_max_y;

    w_nonpos = width[COORD_W-1]  || (width == '0);
    h_nonpos = height[COORD_W-1] || (height == '0);
    empty    = w_nonpos || h_nonpos || (min_x > max_x) || (min_y > max_y);
  end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Bounding-box raster scan: accept -> first pixel 2 cycles later, 1 pixel/cycle, outputs held while pix_ready=0.
// RASTER_STATS_EN adds saturating pixel/triangle counters (stat_pix_cnt, stat_tri_cnt).
module raster_scan_ctrl #(
  parameter int COORD_W = raster_pkg::COORD_W
`ifdef RASTER_STATS_EN
  , parameter int STATS_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic [6*COORD_W-1:0] triangle,
  input  logic [COORD_W-1:0]   width,
  input  logic [COORD_W-1:0]   height,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 done
`ifdef RASTER_STATS_EN
  ,
  output logic [STATS_W-1:0]   stat_pix_cnt,
  output logic [STATS_W-1:0]   stat_tri_cnt
`endif
);
  import raster_pkg::*;

  localparam logic signed [COORD_W-1:0] ONE_C = {{(COORD_W-1){1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic [6*COORD_W-1:0]      tri_q, tri_d;
  logic signed [COORD_W-1:0] width_q, width_d, height_q, height_d;
  logic signed [COORD_W-1:0] min_x_q, min_x_d, min_y_q, min_y_d;
  logic signed [COORD_W-1:0] max_x_q, max_x_d, max_y_q, max_y_d;
  logic signed [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;

  logic signed [COORD_W-1:0] bb_min_x, bb_min_y, bb_max_x, bb_max_y;
  logic                      bb_empty;

  raster_bbox #(.COORD_W(COORD_W)) u_bbox (
    .triangle (tri_q),
    .width    (width_q),
    .height   (height_q),
    .min_x    (bb_min_x),
    .min_y    (bb_min_y),
    .max_x    (bb_max_x),
    .max_y    (bb_max_y),
    .empty    (bb_empty)
  );

  always_comb begin
    state_d  = state_q;
    tri_d    = tri_q;
    width_d  = width_q;
    height_d = height_q;
    min_x_d  = min_x_q;
    min_y_d  = min_y_q;
    max_x_d  = max_x_q;
    max_y_d  = max_y_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;

    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          tri_d    = triangle;
          width_d  = width;
          height_d = height;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        min_x_d = bb_min_x;
        min_y_d = bb_min_y;
        max_x_d = bb_max_x;
        max_y_d = bb_max_y;
        cur_x_d = bb_min_x;
        cur_y_d = bb_min_y;
        state_d = bb_empty ? DONE : SCAN;
      end
      SCAN: begin
        if (pix_ready) begin
          if (cur_x_q != max_x_q) begin
            cur_x_d = cur_x_q + ONE_C;
          end else begin
            cur_x_d = min_x_q;
            if (cur_y_q == max_y_q) begin
              state_d = DONE;
            end else begin
              cur_y_d = cur_y_q + ONE_C;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tri_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      min_x_q  <= '0;
      min_y_q  <= '0;
      max_x_q  <= '0;
      max_y_q  <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      tri_q    <= tri_d;
      width_q  <= width_d;
      height_q <= height_d;
      min_x_q  <= min_x_d;
      min_y_q  <= min_y_d;
      max_x_q  <= max_x_d;
      max_y_q  <= max_y_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
    end
  end

  assign tri_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pix_valid = (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign pix_x     = cur_x_q;
  assign pix_y     = cur_y_q;
  assign pix_last  = (state_q == SCAN) && (cur_x_q == max_x_q) && (cur_y_q == max_y_q);

`ifdef RASTER_STATS_EN
  localparam logic [STATS_W-1:0] STAT_ONE = {{(STATS_W-1){1'b0}}, 1'b1};

  logic [STATS_W-1:0] stat_pix_q, stat_pix_d, stat_tri_q, stat_tri_d;

  always_comb begin
    stat_pix_d = stat_pix_q;
    stat_tri_d = stat_tri_q;
    if (pix_valid && pix_ready && (stat_pix_q != '1)) stat_pix_d = stat_pix_q + STAT_ONE;
    if (done && (stat_tri_q != '1))                   stat_tri_d = stat_tri_q + STAT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pix_q <= '0;
      stat_tri_q <= '0;
    end else begin
      stat_pix_q <= stat_pix_d;
      stat_tri_q <= stat_tri_d;
    end
  end

  assign stat_pix_cnt = stat_pix_q;
  assign stat_tri_cnt = stat_tri_q;
`endif

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed bench for raster_scan_ctrl; checks stats ports when RASTER_STATS_EN is defined.
module tb_raster_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tri_valid;
  logic        tri_ready;
  logic [95:0] triangle;
  logic [15:0] width;
  logic [15:0] height;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        pix_last;
  logic        busy;
  logic        done;
`ifdef RASTER_STATS_EN
  logic [31:0] stat_pix_cnt;
  logic [31:0] stat_tri_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int model_pix = 0;
  int model_tri = 0;

  raster_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .triangle  (triangle),
    .width     (width),
    .height    (height),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
`ifdef RASTER_STATS_EN
    ,
    .stat_pix_cnt (stat_pix_cnt),
    .stat_tri_cnt (stat_tri_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input string what, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s.%s observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  function automatic logic [95:0] tri6(input int x0, input int y0, input int x1,
                                       input int y1, input int x2, input int y2);
    return {16'(x0), 16'(y0), 16'(x1), 16'(y1), 16'(x2), 16'(y2)};
  endfunction

  task automatic chk_stats(input string tag);
`ifdef RASTER_STATS_EN
    chk(tag, "stat_pix_cnt", int'(stat_pix_cnt), model_pix);
    chk(tag, "stat_tri_cnt", int'(stat_tri_cnt), model_tri);
`else
    chk(tag, "busy_idle", int'(busy), 0);
`endif
  endtask

  task automatic accept(input string tag, input logic [95:0] t, input int w, input int h);
    int guard;
    guard = 0;
    while (!tri_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, "tri_ready_pre", int'(tri_ready), 1);
    triangle  = t;
    width     = 16'(w);
    height    = 16'(h);
    tri_valid = 1'b1;
    @(negedge clk);
    chk(tag, "busy_setup", int'(busy), 1);
    chk(tag, "tri_ready_setup", int'(tri_ready), 0);
    chk(tag, "pix_valid_setup", int'(pix_valid), 0);
    // Scramble inputs: the latched copy must be used from here on.
    tri_valid = 1'b0;
    triangle  = {6{16'h7ff0}};
    width     = 16'd0;
    height    = 16'd0;
  endtask

  task automatic run_case(input string tag, input logic [95:0] t, input int w, input int h,
                          input int ex0, input int ex1, input int ey0, input int ey1,
                          input bit empty, input bit rnd);
    bit hs;
    int stall;
    accept(tag, t, w, h);
    pix_ready = 1'b1;
    @(negedge clk);
    if (empty) begin
      chk(tag, "done_empty", int'(done), 1);
      chk(tag, "pix_valid_empty", int'(pix_valid), 0);
      model_tri++;
      @(negedge clk);
      chk(tag, "tri_ready_after", int'(tri_ready), 1);
      chk(tag, "done_after", int'(done), 0);
      chk(tag, "busy_after", int'(busy), 0);
    end else begin
      for (int y = ey0; y <= ey1; y++) begin
        for (int x = ex0; x <= ex1; x++) begin
          hs = 1'b0;
          stall = 0;
          while (!hs) begin
            chk(tag, "pix_valid", int'(pix_valid), 1);
            chk(tag, "pix_x", int'(pix_x), x);
            chk(tag, "pix_y", int'(pix_y), y);
            chk(tag, "pix_last", int'(pix_last), (x == ex1 && y == ey1) ? 1 : 0);
            chk(tag, "done_scan", int'(done), 0);
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall >= 6) pix_ready = 1'b1;
            hs = pix_ready;
            if (!hs) stall++;
            @(negedge clk);
          end
          model_pix++;
        end
      end
      chk(tag, "done_end", int'(done), 1);
      chk(tag, "pix_valid_end", int'(pix_valid), 0);
      model_tri++;
      @(negedge clk);
      chk(tag, "done_clear", int'(done), 0);
      chk(tag, "tri_ready_end", int'(tri_ready), 1);
    end
    pix_ready = 1'b0;
    chk_stats(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    tri_valid = 1'b0;
    pix_ready = 1'b0;
    triangle  = '0;
    width     = '0;
    height    = '0;
    #12;
    chk("reset", "tri_ready", int'(tri_ready), 1);
    chk("reset", "pix_valid", int'(pix_valid), 0);
    chk("reset", "pix_last", int'(pix_last), 0);
    chk("reset", "done", int'(done), 0);
    chk("reset", "busy", int'(busy), 0);
    chk("reset", "pix_x", int'(pix_x), 0);
    chk("reset", "pix_y", int'(pix_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_case("c1_basic", tri6(0, 0, 3, 0, 0, 2), 640, 480, 0, 3, 0, 2, 1'b0, 1'b0);
    run_case("c2_clamp_neg", tri6(-5, -5, 2, -5, -5, 1), 640, 480, 0, 2, 0, 1, 1'b0, 1'b0);
    run_case("c3_offscreen", tri6(700, 10, 710, 10, 705, 20), 640, 480, 0, 0, 0, 0, 1'b1, 1'b0);
    run_case("c4_stall", tri6(0, 0, 3, 0, 0, 2), 640, 480, 0, 3, 0, 2, 1'b0, 1'b1);
    run_case("c5_point", tri6(5, 5, 5, 5, 5, 5), 640, 480, 5, 5, 5, 5, 1'b0, 1'b0);
    run_case("c5_width0", tri6(0, 0, 3, 0, 0, 2), 0, 480, 0, 0, 0, 0, 1'b1, 1'b0);
    run_case("c5_clamp_max", tri6(636, 477, 650, 477, 636, 490), 640, 480, 636, 639, 477, 479,
             1'b0, 1'b1);
    run_case("c5_neg_height", tri6(0, 0, 1, 0, 0, 1), 640, -3, 0, 0, 0, 0, 1'b1, 1'b0);
    run_case("c5_left_off", tri6(-9, 0, -4, 2, -6, 4), 640, 480, 0, 0, 0, 0, 1'b1, 1'b0);

    // Reset in the middle of a scan after three handshakes.
    accept("c6_reset", tri6(0, 0, 3, 0, 0, 2), 640, 480);
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("c6_reset", "pix_x_before", int'(pix_x), 3);
    chk("c6_reset", "pix_valid_before", int'(pix_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c6_reset", "pix_valid_async", int'(pix_valid), 0);
    chk("c6_reset", "busy_async", int'(busy), 0);
    chk("c6_reset", "tri_ready_async", int'(tri_ready), 1);
    chk("c6_reset", "pix_x_async", int'(pix_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix_ready = 1'b0;
    model_pix = 0;
    model_tri = 0;
    @(negedge clk);
    chk("c6_reset", "tri_ready_rel", int'(tri_ready), 1);
    chk("c6_reset", "busy_rel", int'(busy), 0);
    chk_stats("c6_reset");

    run_case("c6_after", tri6(-5, -5, 2, -5, -5, 1), 640, 480, 0, 2, 0, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
